// File: rtl/system2_pkg.sv
// Shared types and constants for the system2 sweep/capture stage.
package system2_pkg;

    localparam int NUM_CODES = 16;
    localparam int CODE_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/system2_sweeper_dwell_timer.sv
// Per-code dwell counter: flags the capture cycle and the final cycle of each code.
module sweep_dwell_timer #(
    parameter int DWELL  = 10,
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic run,
    output logic sample_pulse,
    output logic last_pulse
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (restart || !run) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST_C) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign sample_pulse = run && (r_cnt == SETTLE_C);
    assign last_pulse   = run && (r_cnt == LAST_C);

endmodule

// File: rtl/system2_sweeper.sv
// Walks {vd,vc,vb,va} through codes 0..15 and records system2.outa into a truth table.
module system2_sweeper
    import system2_pkg::*;
#(
    parameter int DWELL  = 10,
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        outa_in,
    output logic        va,
    output logic        vb,
    output logic        vc,
    output logic        vd,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth,
    output logic [4:0]  ones_count
);

    localparam logic [CODE_W-1:0] LAST_CODE = CODE_W'(NUM_CODES - 1);

    state_t                r_state;
    logic [CODE_W-1:0]     r_code;
    logic                  r_busy;
    logic                  r_done;
    logic [NUM_CODES-1:0]  r_truth;
    logic [4:0]            r_ones;

    logic w_restart;
    logic w_run;
    logic w_sample;
    logic w_last;

    assign w_restart = (r_state == IDLE) && start;
    assign w_run     = (r_state == RUN);

    sweep_dwell_timer #(
        .DWELL  (DWELL),
        .SETTLE (SETTLE)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .restart      (w_restart),
        .run          (w_run),
        .sample_pulse (w_sample),
        .last_pulse   (w_last)
    );

    // r_code is forced back to 0 whenever RUN is left, so the stimulus pins idle low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_code  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_truth <= '0;
            r_ones  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_code  <= '0;
                        r_busy  <= 1'b1;
                        r_truth <= '0;
                        r_ones  <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_code  <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        if (w_sample) begin
                            r_truth[r_code] <= outa_in;
                            r_ones          <= r_ones + {4'b0, outa_in};
                        end
                        if (w_last) begin
                            if (r_code == LAST_CODE) begin
                                r_state <= DONE;
                                r_code  <= '0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_code <= r_code + 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_code  <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign {vd, vc, vb, va} = r_code;
    assign busy       = r_busy;
    assign done       = r_done;
    assign truth      = r_truth;
    assign ones_count = r_ones;

endmodule

// File: tb/tb_system2_sweeper.sv
// Directed bench: behavioural system2 models feed outa_in while sweeps are checked against hand tables.
module tb_system2_sweeper;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        outa_in;
    logic        va, vb, vc, vd;
    logic        busy;
    logic        done;
    logic [15:0] truth;
    logic [4:0]  ones_count;

    int mode;   // 0 parity, 1 and4, 2 constant one
    int n_cmp;
    int n_bad;

    system2_sweeper #(.DWELL(10), .SETTLE(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .outa_in    (outa_in),
        .va         (va),
        .vb         (vb),
        .vc         (vc),
        .vd         (vd),
        .busy       (busy),
        .done       (done),
        .truth      (truth),
        .ones_count (ones_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        outa_in = 1'b0;
        case (mode)
            0: outa_in = va ^ vb ^ vc ^ vd;
            1: outa_in = va & vb & vc & vd;
            default: outa_in = 1'b1;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses start (optionally with abort), then observes 200 cycles; cycle 0 is the
    // first negedge after the accepting edge. start is re-pulsed at cycle restart_at.
    task automatic sweep(input string tag, input int restart_at, input logic with_abort,
                         input logic [15:0] exp_truth, input logic [4:0] exp_ones);
        int busy_cyc, code_bad, done_cyc, done_cnt;
        busy_cyc = 0; code_bad = 0; done_cyc = -1; done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        abort = with_abort;
        @(negedge clk);
        abort = 1'b0;
        for (int n = 0; n < 200; n++) begin
            start = (n == restart_at);
            if (busy) busy_cyc++;
            if (n < 160 && {vd, vc, vb, va} != 4'(n / 10)) code_bad++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = n;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_busy_cycles"}, busy_cyc, 160);
        chk({tag, "_done_cycle"}, done_cyc, 160);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_code_seq_errs"}, code_bad, 0);
        chk({tag, "_truth"}, truth, exp_truth);
        chk({tag, "_ones"}, ones_count, exp_ones);
        chk({tag, "_stim_idle"}, {vd, vc, vb, va}, 0);
    endtask

    initial begin
        int waited, done_seen;
        n_cmp = 0; n_bad = 0; mode = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_truth", truth, 0);
        chk("rst_ones", ones_count, 0);
        chk("rst_stim", {vd, vc, vb, va}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Abort in IDLE does nothing
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);

        mode = 0;
        sweep("parity", -1, 1'b0, 16'h6996, 5'd8);
        mode = 1;
        sweep("and4", -1, 1'b0, 16'h8000, 5'd1);
        mode = 0;
        sweep("restart50", 50, 1'b0, 16'h6996, 5'd8);
        mode = 2;
        sweep("ones16_startabort", -1, 1'b1, 16'hFFFF, 5'd16);

        // Abort while code 5 is applied
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while ({vd, vc, vb, va} != 4'd5 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("abort_reach_code5", {vd, vc, vb, va}, 5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_stim", {vd, vc, vb, va}, 0);
        chk("abort_truth", truth, 16'h0016);
        chk("abort_ones", ones_count, 3);
        done_seen = 0;
        for (int n = 0; n < 200; n++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_hold_truth", truth, 16'h0016);

        // Reset in the middle of a sweep
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (80) @(negedge clk);
        chk("mid_busy_before_rst", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_truth", truth, 0);
        chk("midrst_ones", ones_count, 0);
        chk("midrst_stim", {vd, vc, vb, va}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sweep("after_rst", -1, 1'b0, 16'h6996, 5'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
